// File: rtl/seq_detect_arbiter.sv
// rtl/seq_detect_arbiter.sv - round-robin arbiter sharing one serial 4-bit pattern detector
//
// Purpose: grants one of N_REQ requesters at a time, latches its word and
// shifts it MSB-first through a 4-bit history, counting overlapping PAT
// matches. Reports the count tagged with the requester index.
//
// Ports:
//   clk        clock, all state changes on posedge
//   rst        asynchronous active-high reset
//   req        per-requester "word pending"
//   word       packed requester words, requester i at [i*WORD_W +: WORD_W]
//   gnt        one-hot pulse, requester's word was latched (first SHIFT cycle)
//   busy       high whenever the controller is not IDLE
//   done       one-cycle pulse, done_id/match_cnt are valid
//   done_id    index of the requester being reported (held until next report)
//   match_cnt  overlapping PAT occurrences in the word (held until next report)
//
// Optional feature: define SEQ_ARB_BACK2BACK_EN to let REPORT arbitrate too,
// removing the dead IDLE cycle between consecutive words.

module seq_detect_arbiter #(
  parameter int          N_REQ  = 4,
  parameter int          WORD_W = 8,
  parameter logic [3:0]  PAT    = 4'b1101
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*WORD_W-1:0]      word,
  output logic [N_REQ-1:0]             gnt,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(N_REQ)-1:0]     done_id,
  output logic [$clog2(WORD_W+1)-1:0]  match_cnt
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(WORD_W + 1);
  localparam int BW = $clog2(WORD_W);

`ifdef SEQ_ARB_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       cur_q, cur_d;
  logic [BW-1:0]       idx_q, idx_d;
  logic [3:0]          hist_q, hist_d;
  logic [CW-1:0]       acc_q, acc_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic                done_q, done_d;
  logic [IW-1:0]       done_id_q, done_id_d;
  logic [CW-1:0]       match_cnt_q, match_cnt_d;

  logic                sel_valid;
  logic [IW-1:0]       sel_idx;
  logic                grant_go;
  logic [3:0]          hist_shift;

  // Round-robin pick: first requester found scanning upward from the pointer.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!sel_valid && req[(int'(ptr_q) + k) % N_REQ]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  // The word is kept in a left-shifting register so the current bit is
  // always the MSB; idx_q only tracks how many bits have been consumed.
  assign hist_shift = {hist_q[2:0], shreg_q[WORD_W-1]};
  assign grant_go   = sel_valid && ((state_q == IDLE) || (B2B && (state_q == REPORT)));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    idx_d       = idx_q;
    hist_d      = hist_q;
    acc_d       = acc_q;
    shreg_d     = shreg_q;
    gnt_d       = '0;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;

    case (state_q)
      SHIFT: begin
        hist_d  = hist_shift;
        shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
        idx_d   = idx_q + BW'(1);
        // idx_q >= 3 means this is at least the 4th bit of the current word,
        // so the history holds no bits left over from a previous word.
        if ((hist_shift == PAT) && (idx_q >= BW'(3)) && (acc_q != {CW{1'b1}})) begin
          acc_d = acc_q + CW'(1);
        end
        if (idx_q == BW'(WORD_W - 1)) begin
          state_d     = REPORT;
          idx_d       = '0;
          done_d      = 1'b1;
          done_id_d   = cur_q;
          match_cnt_d = acc_d;
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (grant_go) begin
      state_d        = SHIFT;
      shreg_d        = word[sel_idx*WORD_W +: WORD_W];
      gnt_d[sel_idx] = 1'b1;
      cur_d          = sel_idx;
      hist_d         = '0;
      acc_d          = '0;
      idx_d          = '0;
      ptr_d          = IW'((int'(sel_idx) + 1) % N_REQ);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cur_q       <= '0;
      idx_q       <= '0;
      hist_q      <= '0;
      acc_q       <= '0;
      shreg_q     <= '0;
      gnt_q       <= '0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_q       <= cur_d;
      idx_q       <= idx_d;
      hist_q      <= hist_d;
      acc_q       <= acc_d;
      shreg_q     <= shreg_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: doc/seq_detect_arbiter.md
# seq_detect_arbiter

Round-robin controller that shares one serial pattern-detector datapath among `N_REQ` requesters. Each requester presents a parallel word. The controller grants one requester at a time, latches its word, and shifts it MSB-first through an internal 4-bit pattern-matching FSM. It then reports the overlapping match count tagged with the requester index. It sits between the parallel word producers and the bit-serial sequence-detection logic, replacing per-producer detector instances.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `WORD_W`, 8, word width in bits (4..32).
- `PAT`, 4'b1101, 4-bit pattern to detect; first-received bit is `PAT[3]`.
- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N_REQ  bit i: requester i has a word pending.
- `word`  in  N_REQ*WORD_W  requester i word at `[i*WORD_W +: WORD_W]`.
- `gnt`  out  N_REQ  one-hot, one-cycle pulse: requester i's word was latched.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse: result valid.
- `done_id`  out  $clog2(N_REQ)  index of requester whose result is reported.
- `match_cnt`  out  $clog2(WORD_W+1)  number of `PAT` occurrences in the word, overlapping allowed.

## Operation
- Reset values: `gnt`=0, `busy`=0, `done`=0, `done_id`=0, `match_cnt`=0, state=IDLE, round-robin pointer=0, bit counter=0, history=0.
- FSM states are IDLE, SHIFT and REPORT.
- **IDLE**
  - If `req`!=0, arbitrate.
  - On the next edge: latch the selected word, set `gnt` one-hot for that requester, clear history and the match accumulator, set bit index 0, and go to SHIFT.
  - If `req`==0, stay in IDLE.
- **Arbitration**
  - Round-robin. The highest priority is at the pointer, descending through pointer+1, … mod N_REQ.
  - After granting i, the pointer becomes (i+1) mod N_REQ.
  - `req` is sampled only in the arbitration cycle. It is ignored in SHIFT and REPORT.
- **SHIFT**
  - Each cycle consumes latched bit `WORD_W-1-idx`.
  - History is updated as {history[2:0], bit}.
  - A match occurs when the updated history equals `PAT` and at least 4 bits of this word have been consumed. Bits from a previous word never contribute to a match.
  - The accumulator increments on each match and saturates at its maximum.
  - After bit `WORD_W-1` is consumed, go to REPORT.
- **REPORT**
  - `done`=1 for this cycle.
  - `done_id` = granted index.
  - `match_cnt` = accumulator.
  - `done_id` and `match_cnt` hold until the next REPORT.
  - The next state is IDLE (see Configuration).
- **Requester protocol**
  - Hold `req` and `word` stable until `gnt[i]` is seen.
  - Drop `req` in the `gnt` cycle unless another word is ready. A `req` still high at the next arbitration is treated as a new word.
- **Reset mid-operation:** an asynchronous abort. No `done` is produced for the aborted word, and the pointer returns to 0.

## Timing
- Request seen in IDLE at cycle T → `gnt` high in T+1 (first SHIFT cycle) → SHIFT during T+1..T+WORD_W → `done` in T+WORD_W+1.
- Throughput: one word per WORD_W+2 cycles without the macro, one per WORD_W+1 cycles with it.
- `gnt` and `done` are never high in the same cycle, except that with the macro a new `gnt` may immediately follow `done`.
- `busy` is 1 from the first SHIFT cycle through REPORT.

## Configuration
- `SEQ_ARB_BACK2BACK_EN`
  - **Defined:** REPORT also performs arbitration. If `req`!=0, the next edge latches the new word and pulses `gnt`, going directly to SHIFT and skipping IDLE. If `req`==0, go to IDLE.
  - **Undefined:** REPORT always returns to IDLE, with one dead cycle between words.
  - Pointer rules are identical in both cases.

## Test plan
- **Single word:** reset, then `req`=4'b0001 with word0=8'b1101_1010 → `gnt`=4'b0001 one cycle later; `done` WORD_W+1=9 cycles after the IDLE sample; `done_id`=0; `match_cnt`=2.
- **Pattern boundaries:** word=8'hFF → `match_cnt`=0. word=8'b0000_1101 → `match_cnt`=1, the match being on the last bit.
- **No cross-word match:** word 8'b0000_0110 followed by word 8'b1000_0000 → both report `match_cnt`=0.
- **Fairness:** `req`=4'b1111 held continuously → grant order 0,1,2,3,0. Without the macro, consecutive `done` pulses are 10 cycles apart; with `SEQ_ARB_BACK2BACK_EN`, 9 cycles apart.
- **Reset mid-SHIFT:** assert `rst` at bit index 3 of a word → all outputs 0 immediately and no `done` for that word. After release, `req`=4'b0100 is granted first and reports `done_id`=2.
- **Request timing:** a `req` raised during SHIFT is not granted until the next arbitration cycle. `gnt` stays 0 throughout SHIFT (apart from its first cycle) and REPORT.
